// File: rtl/ex_wb_stage.sv
// Execute / write-back stage: ALU, branch resolution, word data-memory access
// with an IDLE/MEM_WAIT handshake FSM, and registered write-back outputs.
// Optional build macro WB_FORWARD_EN adds a write-back bypass on src1/src2
// (selected by the extra rs1_sel/rs2_sel ports that exist only in that build).
module ex_wb_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        immediate_sel,
  input  logic        alu,
  input  logic        lui,
  input  logic        jal,
  input  logic        jalr,
  input  logic        branch,
  input  logic        mem_write,
  input  logic        mem_to_reg,
  input  logic        arithsubtype,
  input  logic        illegal_inst,
  input  logic [31:0] execute_immediate,
  input  logic [31:0] pc,
  input  logic [4:0]  dest_reg_sel,
  input  logic [2:0]  alu_operation,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
`ifdef WB_FORWARD_EN
  input  logic [4:0]  rs1_sel,
  input  logic [4:0]  rs2_sel,
`endif
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic        wb_stall,
  output logic        wb_alu_to_reg,
  output logic        wb_mem_to_reg,
  output logic [4:0]  wb_dest_reg_sel,
  output logic [31:0] wb_result,
  output logic [31:0] wb_read_data,
  output logic        ex_exception
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] MEM_WAIT = 1'b1;

  logic [0:0]      state_q;
  logic [0:0]      state_d;
  logic            squash_q;

  // Request captured when entering MEM_WAIT
  logic            held_we;
  logic            held_load;
  logic [RW-1:0]   held_dest;
  logic [XLEN-1:0] held_addr;
  logic [XLEN-1:0] held_wdata;

  // Response that arrived while the pipeline was stalled
  logic            resp_q;
  logic [XLEN-1:0] resp_data_q;

  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic [XLEN-1:0] op_b;
  logic [4:0]      shamt;
  logic [XLEN-1:0] alu_out;
  logic [XLEN-1:0] ex_result;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic            br_cond;
  logic            valid;
  logic            mem_op;
  logic            misaligned;
  logic            issue;
  logic            redirect;
  logic            rd_nz;
  logic            alu_we;

  logic            mem_done;
  logic            done_load;
  logic [RW-1:0]   done_dest;
  logic [XLEN-1:0] done_data;

  // Operand source: register-file ports, optionally bypassed from write-back
`ifdef WB_FORWARD_EN
  logic            wb_wr;
  logic [XLEN-1:0] wb_val;
  assign wb_wr  = (wb_alu_to_reg | wb_mem_to_reg) && (wb_dest_reg_sel != RW'(0));
  assign wb_val = wb_mem_to_reg ? wb_read_data : wb_result;
  assign src1   = (wb_wr && (wb_dest_reg_sel == rs1_sel)) ? wb_val : rs1_data;
  assign src2   = (wb_wr && (wb_dest_reg_sel == rs2_sel)) ? wb_val : rs2_data;
`else
  assign src1 = rs1_data;
  assign src2 = rs2_data;
`endif

  assign op_b       = immediate_sel ? execute_immediate : src2;
  assign shamt      = op_b[4:0];
  assign pc_plus4   = pc + XLEN'(4);
  assign mem_addr   = src1 + execute_immediate;
  assign jalr_sum   = src1 + execute_immediate;
  assign target     = jalr ? (jalr_sum & ~XLEN'(1)) : (pc + execute_immediate);
  assign valid      = ~squash_q & ~illegal_inst;
  assign mem_op     = mem_write | mem_to_reg;
  assign misaligned = (mem_addr[1:0] != 2'b00);
  assign rd_nz      = (dest_reg_sel != RW'(0));
  assign issue      = reset & ~stall & (state_q == IDLE) & valid & mem_op & ~misaligned;
  assign redirect   = valid & (jal | jalr | (branch & br_cond));
  assign alu_we     = valid & rd_nz & ~mem_op & (alu | lui | jal | jalr);

  // ALU selected by FUNC3
  always_comb begin : alu_comb
    alu_out = '0;
    case (alu_operation)
      3'b000:  alu_out = arithsubtype ? (src1 - op_b) : (src1 + op_b);
      3'b001:  alu_out = src1 << shamt;
      3'b010:  alu_out = XLEN'($signed(src1) < $signed(op_b));
      3'b011:  alu_out = XLEN'(src1 < op_b);
      3'b100:  alu_out = src1 ^ op_b;
      3'b101:  alu_out = arithsubtype ? XLEN'($signed(src1) >>> shamt) : (src1 >> shamt);
      3'b110:  alu_out = src1 | op_b;
      default: alu_out = src1 & op_b;
    endcase
  end

  // Result select for register write-back
  always_comb begin : result_mux
    ex_result = alu_out;
    if (lui) begin
      ex_result = execute_immediate;
    end else if (jal || jalr) begin
      ex_result = pc_plus4;
    end
  end

  // Branch condition by FUNC3; reserved codes never taken
  always_comb begin : branch_cmp
    br_cond = 1'b0;
    case (alu_operation)
      3'b000:  br_cond = (src1 == src2);
      3'b001:  br_cond = (src1 != src2);
      3'b100:  br_cond = ($signed(src1) < $signed(src2));
      3'b101:  br_cond = ($signed(src1) >= $signed(src2));
      3'b110:  br_cond = (src1 < src2);
      3'b111:  br_cond = (src1 >= src2);
      default: br_cond = 1'b0;
    endcase
  end

  // Memory FSM next state, request outputs, stall and completion
  always_comb begin : mem_fsm_comb
    state_d    = state_q;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    wb_stall   = 1'b0;
    mem_done   = 1'b0;
    done_load  = 1'b0;
    done_dest  = '0;
    done_data  = dmem_rdata;
    case (state_q)
      IDLE: begin
        if (issue) begin
          dmem_req   = 1'b1;
          dmem_we    = mem_write;
          dmem_addr  = mem_addr;
          dmem_wdata = src2;
          done_load  = mem_to_reg & rd_nz;
          done_dest  = dest_reg_sel;
          if (dmem_ready) begin
            mem_done = 1'b1;
          end else begin
            wb_stall = 1'b1;
            state_d  = MEM_WAIT;
          end
        end
      end
      default: begin
        done_load = held_load;
        done_dest = held_dest;
        if (resp_q) begin
          done_data = resp_data_q;
          if (!stall) begin
            mem_done = 1'b1;
            state_d  = IDLE;
          end
        end else begin
          dmem_req   = 1'b1;
          dmem_we    = held_we;
          dmem_addr  = held_addr;
          dmem_wdata = held_wdata;
          if (!dmem_ready) begin
            wb_stall = 1'b1;
          end else if (!stall) begin
            mem_done = 1'b1;
            state_d  = IDLE;
          end
        end
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin : mem_fsm_reg
    if (!reset) begin
      state_q <= IDLE;
    end else if (!stall) begin
      state_q <= state_d;
    end
  end

  // Hold the request across MEM_WAIT and capture responses seen during stall
  always_ff @(posedge clk or negedge reset) begin : mem_hold_reg
    if (!reset) begin
      held_we     <= 1'b0;
      held_load   <= 1'b0;
      held_dest   <= '0;
      held_addr   <= '0;
      held_wdata  <= '0;
      resp_q      <= 1'b0;
      resp_data_q <= '0;
    end else begin
      if (issue && !dmem_ready) begin
        held_we    <= mem_write;
        held_load  <= mem_to_reg & rd_nz;
        held_dest  <= dest_reg_sel;
        held_addr  <= mem_addr;
        held_wdata <= src2;
      end
      if ((state_q == MEM_WAIT) && !resp_q && dmem_ready && stall) begin
        resp_q      <= 1'b1;
        resp_data_q <= dmem_rdata;
      end else if (mem_done) begin
        resp_q <= 1'b0;
      end
    end
  end

  // Write-back, redirect, squash and exception registers
  always_ff @(posedge clk or negedge reset) begin : wb_reg
    if (!reset) begin
      wb_alu_to_reg   <= 1'b0;
      wb_mem_to_reg   <= 1'b0;
      wb_dest_reg_sel <= '0;
      wb_result       <= '0;
      wb_read_data    <= '0;
      branch_taken    <= 1'b0;
      branch_target   <= '0;
      squash_q        <= 1'b0;
      ex_exception    <= 1'b0;
    end else if (!stall) begin
      if (mem_done) begin
        wb_alu_to_reg   <= 1'b0;
        wb_mem_to_reg   <= done_load;
        wb_dest_reg_sel <= done_dest;
        wb_read_data    <= done_data;
      end else if (state_q == IDLE) begin
        wb_alu_to_reg   <= alu_we;
        wb_mem_to_reg   <= 1'b0;
        wb_dest_reg_sel <= dest_reg_sel;
        wb_result       <= ex_result;
      end else begin
        wb_alu_to_reg <= 1'b0;
        wb_mem_to_reg <= 1'b0;
      end
      if ((state_q == IDLE) && redirect) begin
        branch_target <= target;
      end
      branch_taken <= (state_q == IDLE) & redirect;
      squash_q     <= (state_q == IDLE) & redirect;
      ex_exception <= (state_q == IDLE) & ~squash_q &
                      (illegal_inst | (mem_op & misaligned));
    end
  end

endmodule
